instruction_loader: RTL and testbench

//   Write-side companion of the instruction memory: assembles a byte stream (e.g. from the

---
 rtl/instruction_loader_if.sv | 25 ++
 rtl/instruction_loader.sv | 106 ++++++++++
 tb/tb_instruction_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream in / instruction-memory write port out, grouped for the instruction loader.
interface instruction_loader_if #(
  parameter int NBITS = 32
);
  logic             i_start;
  logic [7:0]       i_byte;
  logic             i_byte_valid;
  logic             o_ready;
  logic             o_wr_en;
  logic [NBITS-1:0] o_wr_addr;
  logic [NBITS-1:0] o_wr_data;
  logic             o_busy;
  logic             o_done;
  logic             o_overflow;

  modport master (
    output i_start, i_byte, i_byte_valid,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow
  );

  modport slave (
    input  i_start, i_byte, i_byte_valid,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow
  );
endinterface

// File: rtl/instruction_loader.sv
// Packs an MSB-first byte stream into words and writes one word per cycle-after-4th-byte
// at byte addresses 0,4,8,...; stops on HALT_WORD or when the memory is full.
module instruction_loader #(
  parameter int               NBITS     = 32,
  parameter int               CELDAS    = 60,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic                 i_clk,
  input logic                 i_reset,
  instruction_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 4);

  state_t           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] word_q, word_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic ready;
  logic accept;
  logic is_halt;
  logic is_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;

    is_halt = (word_q == HALT_WORD);
    is_full = (addr_q == LAST_ADDR);

    // Dropping ready in a finishing WRITE keeps a trailing byte from being swallowed.
    case (state_q)
      RECV:    ready = 1'b1;
      WRITE:   ready = !(is_halt || is_full);
      default: ready = 1'b0;
    endcase
    accept = ready && bus.i_byte_valid;

    if (accept) begin
      word_d = {word_q[NBITS-9:0], bus.i_byte};
      cnt_d  = cnt_q + 2'd1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_d = RECV;
          addr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RECV: begin
        if (accept && cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        if (is_halt || is_full) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = !is_halt;
        end else begin
          state_d = RECV;
          addr_d  = addr_q + NBITS'(4);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_ready    = ready;
  assign bus.o_wr_en    = (state_q == WRITE);
  assign bus.o_wr_addr  = addr_q;
  assign bus.o_wr_data  = word_q;
  assign bus.o_busy     = (state_q == RECV) || (state_q == WRITE);
  assign bus.o_done     = done_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: byte-queue reference model checked every cycle,
// plus literal expectations on the captured write log.
module tb_instruction_loader;

  localparam int CELDAS = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_loader_if #(.NBITS(32)) bus ();

  instruction_loader #(
    .NBITS(32), .CELDAS(CELDAS), .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit check_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: collect accepted bytes in a queue, a word is due once four are held.
  logic [7:0]  m_q[$];
  bit          m_active = 0;
  bit          m_write  = 0;
  bit          m_done   = 0;
  bit          m_ovf    = 0;
  int          m_addr   = 0;
  logic [31:0] m_wdata  = '0;

  function automatic bit m_finishing();
    return (m_wdata == 32'hFFFFFFFF) || (m_addr == CELDAS - 4);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_write = 0; m_done = 0; m_ovf = 0; m_addr = 0; m_q.delete();
    end else if (m_write) begin
      if (m_finishing()) begin
        m_active = 0; m_done = 1; m_ovf = (m_wdata != 32'hFFFFFFFF);
      end else begin
        m_addr += 4;
        if (bus.i_byte_valid) m_q.push_back(bus.i_byte);
      end
      m_write = 0;
    end else if (m_active) begin
      if (bus.i_byte_valid) begin
        m_q.push_back(bus.i_byte);
        if (m_q.size() == 4) begin
          m_wdata = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_q.delete();
          m_write = 1;
        end
      end
    end else if (bus.i_start) begin
      m_active = 1; m_addr = 0; m_done = 0; m_ovf = 0; m_q.delete();
    end
  end

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    if (check_en) begin
      chk("ready",    {31'd0, bus.o_ready},    {31'd0, m_active && !(m_write && m_finishing())});
      chk("busy",     {31'd0, bus.o_busy},     {31'd0, m_active});
      chk("done",     {31'd0, bus.o_done},     {31'd0, m_done});
      chk("overflow", {31'd0, bus.o_overflow}, {31'd0, m_ovf});
      chk("wr_en",    {31'd0, bus.o_wr_en},    {31'd0, m_write});
      if (m_write) begin
        chk("wr_addr", bus.o_wr_addr, 32'(m_addr));
        chk("wr_data", bus.o_wr_data, m_wdata);
      end
      if (bus.o_wr_en === 1'b1) begin
        log_addr.push_back(bus.o_wr_addr);
        log_data.push_back(bus.o_wr_data);
      end
    end
  end

  task automatic idle(input int n);
    bus.i_byte_valid = 1'b0;
    bus.i_start      = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    bus.i_byte_valid = 1'b0;
    bus.i_start      = 1'b0;
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_byte_valid = 1'b0;
    bus.i_start      = 1'b1;
    @(negedge clk);
    bus.i_start      = 1'b0;
  endtask

  // Holds the byte until the loader takes it; leaves valid high for back-to-back streaming.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    while (bus.o_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic drive_raw(input logic [7:0] b, input int n);
    bus.i_byte       = b;
    bus.i_byte_valid = 1'b1;
    repeat (n) @(negedge clk);
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    bus.i_start      = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_byte_valid = 1'b0;

    // 1: reset state, bytes without start are ignored
    @(negedge clk);
    do_reset(2);
    chk("rst_ready",    {31'd0, bus.o_ready},    32'd0);
    chk("rst_wr_en",    {31'd0, bus.o_wr_en},    32'd0);
    chk("rst_wr_addr",  bus.o_wr_addr,           32'd0);
    chk("rst_wr_data",  bus.o_wr_data,           32'd0);
    chk("rst_busy",     {31'd0, bus.o_busy},     32'd0);
    chk("rst_done",     {31'd0, bus.o_done},     32'd0);
    chk("rst_overflow", {31'd0, bus.o_overflow}, 32'd0);
    check_en = 1'b1;
    drive_raw(8'hA5, 4);
    idle(2);
    chk("t1_no_writes", 32'(log_addr.size()), 32'd0);

    // 2: single word, then next word at addr 4
    pulse_start();
    send_word(32'h0001F021);
    idle(2);
    chk("t2_count1", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      chk("t2_addr0", log_addr[0], 32'd0);
      chk("t2_data0", log_data[0], 32'h0001F021);
    end
    chk("t2_busy", {31'd0, bus.o_busy}, 32'd1);
    send_word(32'h11223344);
    idle(2);
    chk("t2_count2", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      chk("t2_addr1", log_addr[1], 32'd4);
      chk("t2_data1", log_data[1], 32'h11223344);
    end

    // 3: halt word ends the load
    do_reset(1);
    clear_log();
    pulse_start();
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    send_word(32'hFFFFFFFF);
    idle(2);
    chk("t3_count", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() >= 3) begin
      chk("t3_addr2", log_addr[2], 32'd8);
      chk("t3_data2", log_data[2], 32'hFFFFFFFF);
    end
    chk("t3_done",     {31'd0, bus.o_done},     32'd1);
    chk("t3_busy",     {31'd0, bus.o_busy},     32'd0);
    chk("t3_overflow", {31'd0, bus.o_overflow}, 32'd0);
    drive_raw(8'h55, 6);
    idle(2);
    chk("t3_ignored", 32'(log_addr.size()), 32'd3);

    // 4: fill memory without halt, restarting from DONE
    clear_log();
    pulse_start();
    chk("t4_done_cleared", {31'd0, bus.o_done}, 32'd0);
    for (int i = 1; i <= 15; i++) send_word({4{8'(i)}});
    idle(2);
    chk("t4_count", 32'(log_addr.size()), 32'd15);
    if (log_addr.size() >= 15) begin
      chk("t4_last_addr", log_addr[14], 32'd56);
      chk("t4_last_data", log_data[14], 32'h0F0F0F0F);
    end
    chk("t4_done",     {31'd0, bus.o_done},     32'd1);
    chk("t4_overflow", {31'd0, bus.o_overflow}, 32'd1);
    drive_raw(8'h42, 8);
    idle(2);
    chk("t4_no_16th", 32'(log_addr.size()), 32'd15);

    // 5: valid every cycle, no byte lost across WRITE cycles
    do_reset(2);
    clear_log();
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
    idle(3);
    chk("t5_count", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() >= 3) begin
      chk("t5_addr0", log_addr[0], 32'd0);
      chk("t5_data0", log_data[0], 32'h10111213);
      chk("t5_addr1", log_addr[1], 32'd4);
      chk("t5_data1", log_data[1], 32'h14151617);
      chk("t5_addr2", log_addr[2], 32'd8);
      chk("t5_data2", log_data[2], 32'h18191A1B);
    end

    // 6: reset mid-word, then a clean word with a start pulse mid-word
    do_reset(1);
    clear_log();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset(1);
    idle(3);
    chk("t6_abort_no_write", 32'(log_addr.size()), 32'd0);
    chk("t6_abort_busy", {31'd0, bus.o_busy}, 32'd0);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h04);
    idle(2);
    chk("t6_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) begin
      chk("t6_addr", log_addr[0], 32'd0);
      chk("t6_data", log_data[0], 32'h01020304);
    end
    chk("t6_busy", {31'd0, bus.o_busy}, 32'd1);

    idle(2);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
